// File: rtl/bus_mem_responder_pkg.sv
// Shared state encoding and bus-width constants for the bus memory responder.
package bus_mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      COMMIT,
      RESP
   } state_t;

   localparam logic [1:0]  OL_MACHINE = 2'd0;
   localparam int unsigned AMSB       = 79;
   localparam int unsigned DATA_W     = 128;
   localparam int unsigned SEL_W      = 16;

endpackage

// File: rtl/bus_mem_responder_ram.sv
// Single-port 128-bit RAM with 16 byte-lane write enables and a registered read.
module bytewrite_ram_128
   import bus_mem_pkg::*;
#(
   parameter int unsigned ADDR_BITS = 10
) (
   input  logic                 clk_i,
   input  logic                 en,
   input  logic [SEL_W-1:0]     we,
   input  logic [ADDR_BITS-1:0] addr,
   input  logic [DATA_W-1:0]    wdata,
   output logic [DATA_W-1:0]    rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_BITS];

   always_ff @(posedge clk_i) begin
      if (en) begin
         for (int unsigned k = 0; k < SEL_W; k++) begin
            if (we[k]) begin
               mem[addr][k*8 +: 8] <= wdata[k*8 +: 8];
            end
         end
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/bus_mem_responder.sv
// Bus responder decoding one address window into a byte-writable on-chip RAM.
// Optional load-reserved/store-conditional support: define BUS_MEM_RESERVATION_EN.
module bus_mem_responder
   import bus_mem_pkg::*;
#(
   parameter int unsigned   AMSB          = 79,
   parameter int unsigned   MEM_ADDR_BITS = 10,
   parameter logic [AMSB:0] BASE_ADDR     = '0,
   parameter int unsigned   WAIT_STATES   = 1,
   parameter int unsigned   PROT_LINES    = 64
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cyc_i,
   input  logic              stb_i,
   input  logic              we_i,
   input  logic [1:0]        ol_i,
   input  logic [SEL_W-1:0]  sel_i,
   input  logic [AMSB:0]     adr_i,
   input  logic [DATA_W-1:0] dat_i,
   input  logic              cr_i,
   input  logic              sr_i,
   output logic              ack_o,
   output logic              err_o,
   output logic              wrv_o,
   output logic              rb_o,
   output logic [DATA_W-1:0] dat_o
);

   localparam int unsigned LW = MEM_ADDR_BITS;

   state_t              state;
   logic [3:0]          cnt;
   logic [LW-1:0]       req_line;
   logic                req_we;
   logic [SEL_W-1:0]    req_sel;
   logic [DATA_W-1:0]   req_dat;

   logic [LW-1:0]       line;
   logic                hit;
   logic                prot;
   logic                wr_commit;
   logic                rd_issue;
   logic                wr_go;
   logic                ram_en;
   logic [SEL_W-1:0]    ram_we;
   logic [LW-1:0]       ram_addr;
   logic [DATA_W-1:0]   ram_q;
   logic                unused_bits;

`ifdef BUS_MEM_RESERVATION_EN
   logic                req_cr;
   logic                req_sr;
   logic                res_valid;
   logic [LW-1:0]       res_line;
   assign unused_bits = ^adr_i[3:0];
`else
   assign unused_bits = ^{adr_i[3:0], cr_i, sr_i};
`endif

   assign line = adr_i[MEM_ADDR_BITS+3:4];
   assign hit  = (adr_i[AMSB:MEM_ADDR_BITS+4] == BASE_ADDR[AMSB:MEM_ADDR_BITS+4]);
   assign prot = (32'(line) < PROT_LINES);

   always_comb begin
      wr_commit = req_we;
`ifdef BUS_MEM_RESERVATION_EN
      if (req_cr && !(res_valid && (res_line == req_line))) begin
         wr_commit = 1'b0;
      end
`endif
   end

   // Reads are launched at the strobe sample edge so the registered RAM output
   // is already stable by COMMIT, even with zero wait states.
   assign rd_issue = (state == IDLE) && cyc_i && stb_i && !we_i;
   assign wr_go    = (state == COMMIT) && req_we && wr_commit;
   assign ram_en   = !rst_i && cyc_i && (rd_issue || wr_go);
   assign ram_we   = (ram_en && wr_go) ? req_sel : '0;
   assign ram_addr = (state == IDLE) ? line : req_line;

   bytewrite_ram_128 #(
      .ADDR_BITS (MEM_ADDR_BITS)
   ) u_ram (
      .clk_i (clk_i),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (req_dat),
      .rdata (ram_q)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         cnt       <= '0;
         req_line  <= '0;
         req_we    <= 1'b0;
         req_sel   <= '0;
         req_dat   <= '0;
         ack_o     <= 1'b0;
         err_o     <= 1'b0;
         wrv_o     <= 1'b0;
         rb_o      <= 1'b0;
         dat_o     <= '0;
`ifdef BUS_MEM_RESERVATION_EN
         req_cr    <= 1'b0;
         req_sr    <= 1'b0;
         res_valid <= 1'b0;
         res_line  <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (cyc_i && stb_i && !(ack_o || err_o || wrv_o)) begin
                  req_line <= line;
                  req_we   <= we_i;
                  req_sel  <= sel_i;
                  req_dat  <= dat_i;
`ifdef BUS_MEM_RESERVATION_EN
                  req_cr   <= cr_i;
                  req_sr   <= sr_i;
`endif
                  if (!hit) begin
                     err_o <= 1'b1;
                     state <= RESP;
                  end else if (we_i && prot && (ol_i != OL_MACHINE)) begin
                     wrv_o <= 1'b1;
                     state <= RESP;
                  end else if (WAIT_STATES == 0) begin
                     state <= COMMIT;
                  end else begin
                     cnt   <= WAIT_STATES[3:0];
                     state <= WAIT;
                  end
               end
            end

            WAIT: begin
               if (!cyc_i) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt - 4'd1;
                  if (cnt == 4'd1) begin
                     state <= COMMIT;
                  end
               end
            end

            COMMIT: begin
               if (!cyc_i) begin
                  state <= IDLE;
               end else begin
                  ack_o <= 1'b1;
                  state <= RESP;
                  if (req_we) begin
                     rb_o <= wr_commit;
`ifdef BUS_MEM_RESERVATION_EN
                     if (req_cr || (wr_commit && (res_line == req_line))) begin
                        res_valid <= 1'b0;
                     end
`endif
                  end else begin
                     dat_o <= ram_q;
`ifdef BUS_MEM_RESERVATION_EN
                     if (req_sr) begin
                        res_valid <= 1'b1;
                        res_line  <= req_line;
                     end
`endif
                  end
               end
            end

            RESP: begin
               if (!cyc_i || !stb_i) begin
                  ack_o <= 1'b0;
                  err_o <= 1'b0;
                  wrv_o <= 1'b0;
                  rb_o  <= 1'b0;
                  state <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Self-checking bench for bus_mem_responder against a line-array reference model.
module tb_bus_mem_responder;

   localparam logic [79:0] BASE = 80'h0000_0000_0000_1000_0000;
   localparam int          WS   = 1;
   localparam int          PROT = 64;

   logic          clk_i = 1'b0;
   logic          rst_i, cyc_i, stb_i, we_i, cr_i, sr_i;
   logic [1:0]    ol_i;
   logic [15:0]   sel_i;
   logic [79:0]   adr_i;
   logic [127:0]  dat_i;
   logic          ack_o, err_o, wrv_o, rb_o;
   logic [127:0]  dat_o;

   int errors = 0;
   int checks = 0;

   logic [127:0] model_mem [1024];
   logic [127:0] last_rd;
`ifdef BUS_MEM_RESERVATION_EN
   logic         res_valid;
   int           res_line;
`endif

   bus_mem_responder #(
      .AMSB          (79),
      .MEM_ADDR_BITS (10),
      .BASE_ADDR     (BASE),
      .WAIT_STATES   (WS),
      .PROT_LINES    (PROT)
   ) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .cyc_i (cyc_i),
      .stb_i (stb_i),
      .we_i  (we_i),
      .ol_i  (ol_i),
      .sel_i (sel_i),
      .adr_i (adr_i),
      .dat_i (dat_i),
      .cr_i  (cr_i),
      .sr_i  (sr_i),
      .ack_o (ack_o),
      .err_o (err_o),
      .wrv_o (wrv_o),
      .rb_o  (rb_o),
      .dat_o (dat_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [127:0] lane_merge(input logic [127:0] old, input logic [127:0] nw,
                                               input logic [15:0] sel);
      logic [127:0] r;
      r = old;
      for (int k = 0; k < 16; k++) if (sel[k]) r[k*8 +: 8] = nw[k*8 +: 8];
      return r;
   endfunction

   function automatic logic [79:0] line_adr(input int line, input int low);
      return BASE + (80'(line) << 4) + 80'(low);
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Reference model: resp is {ack,err,wrv}; rd is what dat_o should show after the beat.
   task automatic model_access(input logic w, input logic [1:0] ol, input logic [15:0] sel,
                               input logic [79:0] adr, input logic [127:0] dat,
                               input logic cr, input logic sr,
                               output logic [2:0] resp, output logic rb,
                               output logic [127:0] rd, output int lat);
      int  line;
      bit  ok;
      line = int'(adr[13:4]);
      rb   = 1'b0;
      if (adr[79:14] != BASE[79:14]) begin
         resp = 3'b010; lat = 1;
      end else if (w && line < PROT && ol != 2'd0) begin
         resp = 3'b001; lat = 1;
      end else begin
         resp = 3'b100; lat = WS + 2;
         if (w) begin
            ok = 1'b1;
`ifdef BUS_MEM_RESERVATION_EN
            if (cr) begin
               ok = res_valid && (res_line == line);
               res_valid = 1'b0;
            end
            if (ok && res_line == line) res_valid = 1'b0;
`else
            if (cr && sr) ok = 1'b1;
`endif
            if (ok) model_mem[line] = lane_merge(model_mem[line], dat, sel);
            rb = ok;
         end else begin
            last_rd = model_mem[line];
`ifdef BUS_MEM_RESERVATION_EN
            if (sr) begin
               res_valid = 1'b1;
               res_line  = line;
            end
`endif
         end
      end
      rd = last_rd;
   endtask

   task automatic do_beat(input logic w, input logic [1:0] ol, input logic [15:0] sel,
                          input logic [79:0] adr, input logic [127:0] dat,
                          input logic cr, input logic sr, input int hold, input logic keep_cyc,
                          output logic [2:0] resp, output logic [2:0] held, output logic rb,
                          output logic [127:0] rd, output int lat, output logic cleared);
      @(negedge clk_i);
      cyc_i = 1'b1; stb_i = 1'b1; we_i = w; ol_i = ol; sel_i = sel;
      adr_i = adr; dat_i = dat; cr_i = cr; sr_i = sr;
      lat  = 0;
      resp = 3'b000;
      while (resp == 3'b000 && lat < 40) begin
         @(posedge clk_i); #1;
         lat++;
         resp = {ack_o, err_o, wrv_o};
      end
      rb = rb_o;
      rd = dat_o;
      repeat (hold) begin @(posedge clk_i); #1; end
      held = {ack_o, err_o, wrv_o};
      stb_i = 1'b0; we_i = 1'b0; cr_i = 1'b0; sr_i = 1'b0;
      if (!keep_cyc) cyc_i = 1'b0;
      @(posedge clk_i); #1;
      cleared = ({ack_o, err_o, wrv_o, rb_o} == 4'b0000);
   endtask

   task automatic test_reset();
      rst_i = 1'b1; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; cr_i = 1'b0; sr_i = 1'b0;
      ol_i = 2'd0; sel_i = '0; adr_i = '0; dat_i = '0;
      last_rd = '0;
`ifdef BUS_MEM_RESERVATION_EN
      res_valid = 1'b0; res_line = 0;
`endif
      repeat (3) @(posedge clk_i);
      #1;
      checks++;
      if ({ack_o, err_o, wrv_o, rb_o} !== 4'b0000) begin
         errors++; $display("FAIL reset_flags: got %b want 0000", {ack_o, err_o, wrv_o, rb_o});
      end
      checks++;
      if (dat_o !== '0) begin errors++; $display("FAIL reset_dat: got %h want 0", dat_o); end
      @(negedge clk_i); rst_i = 1'b0;
   endtask

   task automatic test_init();
      logic [2:0] r, h, er; logic rb, erb, cl; logic [127:0] rd, erd, d; int lat, elat;
      for (int line = 0; line < 1024; line++) begin
         d = rnd128();
         model_access(1'b1, 2'd0, 16'hFFFF, line_adr(line, 0), d, 1'b0, 1'b0, er, erb, erd, elat);
         do_beat(1'b1, 2'd0, 16'hFFFF, line_adr(line, 0), d, 1'b0, 1'b0, 0, 1'b0, r, h, rb, rd, lat, cl);
         checks++;
         if (r !== er || rb !== erb) begin
            errors++; $display("FAIL init_write line %0d: resp %b rb %b want %b %b", line, r, rb, er, erb);
         end
      end
   endtask

   task automatic test_write_read();
      logic [2:0] r, h, er; logic rb, erb, cl; logic [127:0] rd, erd, d; int lat, elat;
      d = {$urandom, $urandom, 32'hDEADBEEF, $urandom};
      model_access(1'b1, 2'd3, 16'h00F0, BASE + 80'h400, d, 1'b0, 1'b0, er, erb, erd, elat);
      do_beat(1'b1, 2'd3, 16'h00F0, BASE + 80'h400, d, 1'b0, 1'b0, 0, 1'b0, r, h, rb, rd, lat, cl);
      checks++;
      if (r !== 3'b100 || lat != 3) begin
         errors++; $display("FAIL wr_ack: resp %b lat %0d want 100 lat 3", r, lat);
      end
      checks++;
      if (rb !== 1'b1 || cl !== 1'b1) begin
         errors++; $display("FAIL wr_rb_clear: rb %b cleared %b want 1 1", rb, cl);
      end
      model_access(1'b0, 2'd3, 16'h0, BASE + 80'h400, '0, 1'b0, 1'b0, er, erb, erd, elat);
      do_beat(1'b0, 2'd3, 16'h0, BASE + 80'h400, '0, 1'b0, 1'b0, 0, 1'b0, r, h, rb, rd, lat, cl);
      checks++;
      if (rd[63:32] !== 32'hDEADBEEF) begin
         errors++; $display("FAIL rd_lane: got %h want deadbeef", rd[63:32]);
      end
      checks++;
      if (rd !== erd || r !== 3'b100 || lat != 3 || rb !== 1'b0) begin
         errors++; $display("FAIL rd_line: got %h resp %b lat %0d rb %b want %h 100 3 0", rd, r, lat, rb, erd);
      end
   endtask

   task automatic test_two_beat();
      logic [2:0] r1, r2, h, er; logic rb1, rb2, erb, cl1, cl2; logic [127:0] rd, erd, d1, d2;
      int lat1, lat2, elat;
      d1 = rnd128(); d2 = rnd128();
      model_access(1'b1, 2'd1, 16'hF000, BASE + 80'h80C, d1, 1'b0, 1'b0, er, erb, erd, elat);
      model_access(1'b1, 2'd1, 16'h000F, BASE + 80'h810, d2, 1'b0, 1'b0, er, erb, erd, elat);
      do_beat(1'b1, 2'd1, 16'hF000, BASE + 80'h80C, d1, 1'b0, 1'b0, 0, 1'b1, r1, h, rb1, rd, lat1, cl1);
      checks++;
      if (cyc_i !== 1'b1 || cl1 !== 1'b1) begin
         errors++; $display("FAIL two_beat_gap: cleared %b want 1", cl1);
      end
      do_beat(1'b1, 2'd1, 16'h000F, BASE + 80'h810, d2, 1'b0, 1'b0, 0, 1'b0, r2, h, rb2, rd, lat2, cl2);
      checks++;
      if (r1 !== 3'b100 || r2 !== 3'b100 || lat1 != 3 || lat2 != 3) begin
         errors++; $display("FAIL two_beat_acks: %b/%0d %b/%0d want 100/3 100/3", r1, lat1, r2, lat2);
      end
      for (int line = 'h80; line <= 'h81; line++) begin
         model_access(1'b0, 2'd0, 16'h0, line_adr(line, 0), '0, 1'b0, 1'b0, er, erb, erd, elat);
         do_beat(1'b0, 2'd0, 16'h0, line_adr(line, 0), '0, 1'b0, 1'b0, 0, 1'b0, r1, h, rb1, rd, lat1, cl1);
         checks++;
         if (rd !== erd) begin
            errors++; $display("FAIL two_beat_line %h: got %h want %h", line, rd, erd);
         end
      end
   endtask

   task automatic test_protect();
      logic [2:0] r, h, er; logic rb, erb, cl; logic [127:0] rd, erd, d; int lat, elat;
      logic [79:0] a [4];
      logic [1:0]  o [4];
      logic [2:0]  want [4];
      a = '{BASE + 80'h010, BASE + 80'h010, BASE + 80'h3F0, BASE + 80'h400};
      o = '{2'd2, 2'd0, 2'd1, 2'd1};
      want = '{3'b001, 3'b100, 3'b001, 3'b100};
      for (int i = 0; i < 4; i++) begin
         d = rnd128();
         model_access(1'b1, o[i], 16'hFFFF, a[i], d, 1'b0, 1'b0, er, erb, erd, elat);
         do_beat(1'b1, o[i], 16'hFFFF, a[i], d, 1'b0, 1'b0, 0, 1'b0, r, h, rb, rd, lat, cl);
         checks++;
         if (r !== want[i] || lat != elat || rb !== erb || rd !== erd) begin
            errors++; $display("FAIL prot_%0d: resp %b lat %0d rb %b want %b %0d %b", i, r, lat, rb, want[i], elat, erb);
         end
         model_access(1'b0, 2'd2, 16'h0, a[i], '0, 1'b0, 1'b0, er, erb, erd, elat);
         do_beat(1'b0, 2'd2, 16'h0, a[i], '0, 1'b0, 1'b0, 0, 1'b0, r, h, rb, rd, lat, cl);
         checks++;
         if (r !== 3'b100 || rd !== erd) begin
            errors++; $display("FAIL prot_rd_%0d: resp %b data %h want 100 %h", i, r, rd, erd);
         end
      end
   endtask

   task automatic test_window();
      logic [2:0] r, h, er; logic rb, erb, cl; logic [127:0] rd, erd; int lat, elat;
      do_beat(1'b0, 2'd0, 16'h0, BASE + 80'h100000, '0, 1'b0, 1'b0, 3, 1'b0, r, h, rb, rd, lat, cl);
      checks++;
      if (r !== 3'b010 || lat != 1 || h !== 3'b010 || cl !== 1'b1) begin
         errors++; $display("FAIL win_err: resp %b lat %0d held %b cleared %b want 010 1 010 1", r, lat, h, cl);
      end
      do_beat(1'b1, 2'd2, 16'hFFFF, BASE + 80'h4010, '1, 1'b0, 1'b0, 0, 1'b0, r, h, rb, rd, lat, cl);
      checks++;
      if (r !== 3'b010) begin errors++; $display("FAIL win_err_prio: resp %b want 010", r); end
      model_access(1'b0, 2'd0, 16'h0, BASE + 80'h3FF0, '0, 1'b0, 1'b0, er, erb, erd, elat);
      do_beat(1'b0, 2'd0, 16'h0, BASE + 80'h3FFF, '0, 1'b0, 1'b0, 0, 1'b0, r, h, rb, rd, lat, cl);
      checks++;
      if (r !== 3'b100 || rd !== erd) begin
         errors++; $display("FAIL win_last_line: resp %b data %h want 100 %h", r, rd, erd);
      end
      do_beat(1'b0, 2'd0, 16'h0, BASE - 80'h10, '0, 1'b0, 1'b0, 0, 1'b0, r, h, rb, rd, lat, cl);
      checks++;
      if (r !== 3'b010 || rd !== last_rd) begin
         errors++; $display("FAIL win_below: resp %b data %h want 010 %h", r, rd, last_rd);
      end
   endtask

   task automatic test_abort();
      logic [2:0] r, h, er; logic rb, erb, cl; logic [127:0] rd, erd; int lat, elat, n, seen;
      for (int pass = 0; pass < 2; pass++) begin
         @(negedge clk_i);
         cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; ol_i = 2'd0; sel_i = 16'hFFFF;
         adr_i = line_adr(5 + pass, 0); dat_i = rnd128();
         @(posedge clk_i); #1;
         if (pass == 0) begin cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; end
         else rst_i = 1'b1;
         @(posedge clk_i); #1;
         rst_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
         seen = 0;
         repeat (6) begin @(posedge clk_i); #1; if (ack_o | err_o | wrv_o) seen++; end
         checks++;
         if (seen != 0) begin errors++; $display("FAIL abort_%0d_resp: got %0d responses want 0", pass, seen); end
         if (pass == 1) begin
            last_rd = '0;
`ifdef BUS_MEM_RESERVATION_EN
            res_valid = 1'b0;
`endif
         end
         model_access(1'b0, 2'd0, 16'h0, line_adr(5 + pass, 0), '0, 1'b0, 1'b0, er, erb, erd, elat);
         do_beat(1'b0, 2'd0, 16'h0, line_adr(5 + pass, 0), '0, 1'b0, 1'b0, 0, 1'b0, r, h, rb, rd, lat, cl);
         checks++;
         if (r !== 3'b100 || rd !== erd) begin
            errors++; $display("FAIL abort_%0d_data: resp %b got %h want %h", pass, r, rd, erd);
         end
      end
      @(negedge clk_i);
      cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = line_adr(5, 0);
      n = 0;
      while (ack_o !== 1'b1 && n < 40) begin @(posedge clk_i); #1; n++; end
      checks++;
      if (ack_o !== 1'b1) begin errors++; $display("FAIL rst_resp_ack: got %b want 1", ack_o); end
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      checks++;
      if ({ack_o, err_o, wrv_o, rb_o} !== 4'b0000 || dat_o !== '0) begin
         errors++; $display("FAIL rst_in_resp: flags %b dat %h want 0000 0", {ack_o, err_o, wrv_o, rb_o}, dat_o);
      end
      rst_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0;
      last_rd = '0;
`ifdef BUS_MEM_RESERVATION_EN
      res_valid = 1'b0;
`endif
   endtask

   task automatic test_reservation();
      logic [2:0] r, h, er; logic rb, erb, cl; logic [127:0] rd, erd, d1, d2, d3; int lat, elat;
      logic [79:0] a;
`ifdef BUS_MEM_RESERVATION_EN
      localparam logic EXP_RB_STALE = 1'b0;
`else
      localparam logic EXP_RB_STALE = 1'b1;
`endif
      a = BASE + 80'h500;
      d1 = rnd128(); d2 = rnd128(); d3 = rnd128();
      model_access(1'b0, 2'd0, 16'h0, a, '0, 1'b0, 1'b1, er, erb, erd, elat);
      do_beat(1'b0, 2'd0, 16'h0, a, '0, 1'b0, 1'b1, 0, 1'b0, r, h, rb, rd, lat, cl);
      model_access(1'b1, 2'd0, 16'hFFFF, a, d1, 1'b1, 1'b0, er, erb, erd, elat);
      do_beat(1'b1, 2'd0, 16'hFFFF, a, d1, 1'b1, 1'b0, 0, 1'b0, r, h, rb, rd, lat, cl);
      checks++;
      if (r !== 3'b100 || rb !== 1'b1) begin
         errors++; $display("FAIL resv_ok: resp %b rb %b want 100 1", r, rb);
      end
      model_access(1'b0, 2'd0, 16'h0, a, '0, 1'b0, 1'b1, er, erb, erd, elat);
      do_beat(1'b0, 2'd0, 16'h0, a, '0, 1'b0, 1'b1, 0, 1'b0, r, h, rb, rd, lat, cl);
      checks++;
      if (rd !== d1) begin errors++; $display("FAIL resv_data1: got %h want %h", rd, d1); end
      model_access(1'b1, 2'd0, 16'h00FF, a, d2, 1'b0, 1'b0, er, erb, erd, elat);
      do_beat(1'b1, 2'd0, 16'h00FF, a, d2, 1'b0, 1'b0, 0, 1'b0, r, h, rb, rd, lat, cl);
      d2 = {d1[127:64], d2[63:0]};
      model_access(1'b1, 2'd0, 16'hFFFF, a, d3, 1'b1, 1'b0, er, erb, erd, elat);
      do_beat(1'b1, 2'd0, 16'hFFFF, a, d3, 1'b1, 1'b0, 0, 1'b0, r, h, rb, rd, lat, cl);
      checks++;
      if (r !== 3'b100 || rb !== EXP_RB_STALE) begin
         errors++; $display("FAIL resv_stale: resp %b rb %b want 100 %b", r, rb, EXP_RB_STALE);
      end
      model_access(1'b0, 2'd0, 16'h0, a, '0, 1'b0, 1'b0, er, erb, erd, elat);
      do_beat(1'b0, 2'd0, 16'h0, a, '0, 1'b0, 1'b0, 0, 1'b0, r, h, rb, rd, lat, cl);
      checks++;
      if (rd !== (EXP_RB_STALE ? d3 : d2)) begin
         errors++; $display("FAIL resv_data2: got %h want %h", rd, EXP_RB_STALE ? d3 : d2);
      end
   endtask

   task automatic test_random();
      logic [2:0] r, h, er; logic rb, erb, cl; logic [127:0] rd, erd, d; int lat, elat;
      logic w, cr, sr; logic [1:0] ol; logic [15:0] sel; logic [79:0] a; int line, hot [8];
      hot = '{1, 2, 63, 64, 65, 'h50, 'h80, 1023};
      for (int i = 0; i < 400; i++) begin
         line = ($urandom % 2 == 1) ? hot[$urandom % 8] : int'($urandom_range(0, 1023));
         a = line_adr(line, int'($urandom % 16));
         if ($urandom % 8 == 0) begin
            int b;
            b = int'($urandom_range(14, 79));
            a[b] = ~a[b];
         end
         w   = 1'($urandom % 2);
         ol  = ($urandom % 2 == 1) ? 2'd0 : 2'($urandom % 4);
         sel = ($urandom % 8 == 0) ? 16'h0 : 16'($urandom);
         cr  = 1'($urandom % 2);
         sr  = 1'($urandom % 2);
         d   = rnd128();
         model_access(w, ol, sel, a, d, cr, sr, er, erb, erd, elat);
         do_beat(w, ol, sel, a, d, cr, sr, 0, 1'b0, r, h, rb, rd, lat, cl);
         checks++;
         if (r !== er || lat != elat) begin
            errors++; $display("FAIL rand_resp %0d: resp %b lat %0d want %b %0d", i, r, lat, er, elat);
         end
         checks++;
         if (rb !== erb || rd !== erd || cl !== 1'b1) begin
            errors++; $display("FAIL rand_data %0d: rb %b dat %h clr %b want %b %h 1", i, rb, rd, cl, erb, erd);
         end
      end
   endtask

   initial begin
      test_reset();
      test_init();
      test_write_read();
      test_two_beat();
      test_protect();
      test_window();
      test_abort();
      test_reservation();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
